pe_row_sequencer: RTL and testbench
===================================

# pe_row_sequencer

Controller that drives a single SV_PE through a 1-D convolution of one ifmap row with a K-tap filter.
- Loads filter taps and a sliding ifmap window, then issues operand pairs plus `mult_seln`/`acc_seln` to the PE.
- Waits out the PE pipeline latency, captures each finished partial sum, and hands it downstream over a valid/ready port.
- Sits between the accelerator's buffer/DMA logic and one PE; the PE array top instantiates one per PE row.

## Interface
- `DATA_WIDTH`, 16: operand width; psum is `2*DATA_WIDTH`.
- `MAX_K`, 7: maximum kernel length.
- `MAX_W`, 64: maximum ifmap row length.
- `PE_LAT`, 4: cycles from the last tap issue cycle to the cycle in which `pe_psum` holds that output's final sum.
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a row; honoured only in IDLE.
- `cfg_k`  in  $clog2(MAX_K+1)  kernel length; sampled on accepted `start`.
- `cfg_w`  in  $clog2(MAX_W+1)  ifmap row length; sampled on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse, row complete.
- `cfg_err`  out  1  one-cycle pulse, illegal config rejected.
- `fltr_valid` / `fltr_ready`  in / out  1  filter tap handshake.
- `fltr_data`  in  DATA_WIDTH  filter tap, tap 0 first.
- `ifmap_valid` / `ifmap_ready`  in / out  1  ifmap sample handshake.
- `ifmap_data`  in  DATA_WIDTH  ifmap sample, index 0 first.
- `pe_ifmap`, `pe_fltr`  out  DATA_WIDTH  operands to PE.
- `pe_mult_seln`  out  1  1 = PE accumulates fresh product this cycle.
- `pe_acc_seln`  out  1  1 = PE clears accumulator feedback.
- `pe_psum`  in  2*DATA_WIDTH  PE partial sum.
- `psum_valid` / `psum_ready`  out / in  1  result handshake.
- `psum_data`  out  2*DATA_WIDTH  captured result.

## Operation
- Transfers complete on cycles where valid and ready are both high.
- **States:** IDLE, LOAD_FLT, LOAD_WIN, MAC, DRAIN, OUT, SHIFT.
- **IDLE:**
  - `start` with legal config (1≤K≤MAX_K, K≤W≤MAX_W) latches K and W, clears tap/output counters, and goes to LOAD_FLT.
  - Illegal config pulses `cfg_err`, stays IDLE, and sets no other flags.
- **LOAD_FLT:** `fltr_ready`=1; stores K taps into fltr[0..K-1], then goes to LOAD_WIN.
- **LOAD_WIN:** `ifmap_ready`=1; stores K samples into win[0..K-1], then goes to MAC.
- **MAC:**
  - Exactly K cycles; tap index i = 0..K-1 in successive cycles.
  - `pe_ifmap`=win[i], `pe_fltr`=fltr[i], `pe_mult_seln`=1.
  - `pe_acc_seln`=1 only at i=0.
  - Then goes to DRAIN.
- **DRAIN:** PE_LAT cycles with `pe_mult_seln`=0 and `pe_acc_seln`=0. The last DRAIN cycle registers `pe_psum` into `psum_data`, then goes to OUT.
- **OUT:**
  - `psum_valid`=1; `psum_data` is stable until accepted.
  - On acceptance, the output count increments.
  - If the count equals W-K+1: pulse `done`, deassert `busy`, go to IDLE. Otherwise go to SHIFT.
- **SHIFT:** `ifmap_ready`=1. On accept, win[j] ← win[j+1] for j<K-1 and win[K-1] ← `ifmap_data`, then go to MAC.
- **Operand defaults:**
  - Outside MAC: `pe_ifmap`=`pe_fltr`=0 and `pe_mult_seln`=0.
  - `pe_acc_seln`=1 in IDLE, LOAD_FLT, LOAD_WIN, OUT, SHIFT.
- **Handshake stalls:** a missing valid or ready in LOAD_FLT, LOAD_WIN, SHIFT or OUT stalls in place with no counter change. MAC and DRAIN never stall.
- **Ignored inputs:**
  - `start` while busy is ignored.
  - `cfg_k`/`cfg_w` changes after acceptance are ignored.
  - Data on `fltr_*`/`ifmap_*` outside their states is not consumed (ready=0).
- **Widths:** `psum_data` is a verbatim copy of `pe_psum`; no arithmetic in the block. Counters are sized to MAX_K, MAX_W.

## Timing
- **Reset values:** all outputs 0 except `pe_acc_seln`=1; state IDLE; fltr/win arrays cleared.
- **Mid-row reset:** `rstn` low at any time returns to IDLE asynchronously; the row is abandoned and no `done` is issued.
- **First result latency:** with no stalls, if `start` is accepted at cycle 0, the first `psum_valid` rises at cycle 3K+PE_LAT+1.
- **Result spacing:** with no stalls, after an OUT acceptance at cycle t, the next `psum_valid` rises at t+K+PE_LAT+2.
- **`done`:** asserted in the cycle after the final OUT acceptance, with `busy`=0 in that same cycle; a new `start` is accepted that cycle.
- **K=W:** exactly one output; SHIFT is never entered.

## Test plan
- **Basic row:** K=3, W=5, filter [1,2,3], ifmap [1,2,3,4,5], behavioural PE with PE_LAT=4, all valids/readies high.
  - Outputs 14, 20, 26.
  - First `psum_valid` at cycle 14; spacing 9; `done` one cycle after third accept.
- **Backpressure:** same row, `psum_ready` low for 5 cycles on output 2 and `ifmap_valid` gapped in SHIFT.
  - `psum_data`=20 held stable throughout.
  - Results unchanged, no duplicate or lost outputs.
- **Config errors:** `start` with K=0, K=8, W=2<K=3, and W=65.
  - Each gives a single `cfg_err` pulse, `busy` stays 0, `fltr_ready` stays 0.
- **Minimum case:** K=1, W=1, filter [−2], ifmap [7].
  - Single output 0xFFFF_FFF2 (−14); `done` after accept; SHIFT never visited.
- **Mid-row reset:** assert `rstn` low during the DRAIN of output 2, then run a fresh row.
  - Outputs go to reset values immediately; no `done`.
  - The next row produces the correct results.
- **Busy start:** `start` pulsed with different cfg during MAC.
  - Ignored; the current row completes with its original K and W.

Source files
------------

// File: rtl/pe_row_sequencer.sv
// pe_row_sequencer: steps one PE through a 1-D convolution of an ifmap row with a K-tap
// filter. Loads taps and a K-wide sliding window, issues K MAC cycles per output, waits out
// the PE pipeline, then hands each finished partial sum downstream over valid/ready.
module pe_row_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_K      = 7,
  parameter int MAX_W      = 64,
  parameter int PE_LAT     = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [$clog2(MAX_K+1)-1:0]   cfg_k,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_w,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  input  logic                         fltr_valid,
  output logic                         fltr_ready,
  input  logic [DATA_WIDTH-1:0]        fltr_data,
  input  logic                         ifmap_valid,
  output logic                         ifmap_ready,
  input  logic [DATA_WIDTH-1:0]        ifmap_data,
  output logic [DATA_WIDTH-1:0]        pe_ifmap,
  output logic [DATA_WIDTH-1:0]        pe_fltr,
  output logic                         pe_mult_seln,
  output logic                         pe_acc_seln,
  input  logic [2*DATA_WIDTH-1:0]      pe_psum,
  output logic                         psum_valid,
  input  logic                         psum_ready,
  output logic [2*DATA_WIDTH-1:0]      psum_data
);

  localparam int KW = $clog2(MAX_K + 1);
  localparam int WW = $clog2(MAX_W + 1);
  localparam int LW = $clog2(PE_LAT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoadFlt, StLoadWin, StMac, StDrain, StOut, StShift
  } state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [WW-1:0]          w_q, w_d;
  logic [KW-1:0]          cnt_q, cnt_d;       // tap / window-load / MAC index
  logic [LW-1:0]          lat_q, lat_d;       // drain cycle counter
  logic [WW-1:0]          out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0]  fltr_q [MAX_K];
  logic [DATA_WIDTH-1:0]  fltr_d [MAX_K];
  logic [DATA_WIDTH-1:0]  win_q  [MAX_K];
  logic [DATA_WIDTH-1:0]  win_d  [MAX_K];

  logic                    busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic                    fltr_ready_q, fltr_ready_d, ifmap_ready_q, ifmap_ready_d;
  logic                    pe_mult_seln_q, pe_mult_seln_d, pe_acc_seln_q, pe_acc_seln_d;
  logic [DATA_WIDTH-1:0]   pe_ifmap_q, pe_ifmap_d, pe_fltr_q, pe_fltr_d;
  logic                    psum_valid_q, psum_valid_d;
  logic [2*DATA_WIDTH-1:0] psum_data_q, psum_data_d;

  logic cfg_legal;
  assign cfg_legal = (cfg_k != '0) && (int'(cfg_k) <= MAX_K) &&
                     (cfg_w >= WW'(cfg_k)) && (int'(cfg_w) <= MAX_W);

  // Next state, counters, arrays; outputs are derived from the next state so they register.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    out_cnt_d   = out_cnt_q;
    fltr_d      = fltr_q;
    win_d       = win_q;
    psum_data_d = psum_data_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_legal) begin
            k_d       = cfg_k;
            w_d       = cfg_w;
            cnt_d     = '0;
            out_cnt_d = '0;
            state_d   = StLoadFlt;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StLoadFlt: begin
        if (fltr_valid && fltr_ready_q) begin
          fltr_d[cnt_q] = fltr_data;
          if (cnt_q == k_q - KW'(1)) begin
            cnt_d   = '0;
            state_d = StLoadWin;
          end else begin
            cnt_d = cnt_q + KW'(1);
          end
        end
      end
      StLoadWin: begin
        if (ifmap_valid && ifmap_ready_q) begin
          win_d[cnt_q] = ifmap_data;
          if (cnt_q == k_q - KW'(1)) begin
            cnt_d   = '0;
            state_d = StMac;
          end else begin
            cnt_d = cnt_q + KW'(1);
          end
        end
      end
      StMac: begin
        if (cnt_q == k_q - KW'(1)) begin
          cnt_d   = '0;
          lat_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StDrain: begin
        // pe_psum carries the final sum in the last drain cycle
        if (lat_q == LW'(PE_LAT - 1)) begin
          psum_data_d = pe_psum;
          state_d     = StOut;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      StOut: begin
        if (psum_valid_q && psum_ready) begin
          out_cnt_d = out_cnt_q + WW'(1);
          if (out_cnt_d == w_q - WW'(k_q) + WW'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (ifmap_valid && ifmap_ready_q) begin
          for (int j = 0; j < MAX_K - 1; j++) begin
            if (j + 1 < int'(k_q)) win_d[j] = win_q[j+1];
          end
          win_d[k_q - KW'(1)] = ifmap_data;
          cnt_d   = '0;
          state_d = StMac;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d         = (state_d != StIdle);
    fltr_ready_d   = (state_d == StLoadFlt);
    ifmap_ready_d  = (state_d == StLoadWin) || (state_d == StShift);
    pe_mult_seln_d = (state_d == StMac);
    pe_acc_seln_d  = ((state_d != StMac) && (state_d != StDrain)) ||
                     ((state_d == StMac) && (cnt_d == '0));
    pe_ifmap_d     = (state_d == StMac) ? win_d[cnt_d]  : '0;
    pe_fltr_d      = (state_d == StMac) ? fltr_d[cnt_d] : '0;
    psum_valid_d   = (state_d == StOut);
  end

  // State and registered outputs; reset abandons any row in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      k_q            <= '0;
      w_q            <= '0;
      cnt_q          <= '0;
      lat_q          <= '0;
      out_cnt_q      <= '0;
      fltr_q         <= '{default: '0};
      win_q          <= '{default: '0};
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      fltr_ready_q   <= 1'b0;
      ifmap_ready_q  <= 1'b0;
      pe_mult_seln_q <= 1'b0;
      pe_acc_seln_q  <= 1'b1;
      pe_ifmap_q     <= '0;
      pe_fltr_q      <= '0;
      psum_valid_q   <= 1'b0;
      psum_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      w_q            <= w_d;
      cnt_q          <= cnt_d;
      lat_q          <= lat_d;
      out_cnt_q      <= out_cnt_d;
      fltr_q         <= fltr_d;
      win_q          <= win_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
      fltr_ready_q   <= fltr_ready_d;
      ifmap_ready_q  <= ifmap_ready_d;
      pe_mult_seln_q <= pe_mult_seln_d;
      pe_acc_seln_q  <= pe_acc_seln_d;
      pe_ifmap_q     <= pe_ifmap_d;
      pe_fltr_q      <= pe_fltr_d;
      psum_valid_q   <= psum_valid_d;
      psum_data_q    <= psum_data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign fltr_ready   = fltr_ready_q;
  assign ifmap_ready  = ifmap_ready_q;
  assign pe_mult_seln = pe_mult_seln_q;
  assign pe_acc_seln  = pe_acc_seln_q;
  assign pe_ifmap     = pe_ifmap_q;
  assign pe_fltr      = pe_fltr_q;
  assign psum_valid   = psum_valid_q;
  assign psum_data    = psum_data_q;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Bench for pe_row_sequencer: behavioural PE, queue-based stream environment, and a
// reference convolution computed directly from the filter and ifmap arrays.
module tb_pe_row_sequencer;
  localparam int DW     = 16;
  localparam int MAX_K  = 7;
  localparam int MAX_W  = 64;
  localparam int PE_LAT = 4;
  localparam int KW     = $clog2(MAX_K + 1);
  localparam int WW     = $clog2(MAX_W + 1);

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic [WW-1:0] cfg_w = '0;
  logic          busy, done, cfg_err, fltr_ready, ifmap_ready;
  logic          pe_mult_seln, pe_acc_seln, psum_valid;
  logic          fltr_valid = 1'b0, ifmap_valid = 1'b0, psum_ready = 1'b0;
  logic [DW-1:0] fltr_data = '0, ifmap_data = '0, pe_ifmap, pe_fltr;
  logic [2*DW-1:0] pe_psum, psum_data;

  pe_row_sequencer #(.DATA_WIDTH(DW), .MAX_K(MAX_K), .MAX_W(MAX_W), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_k(cfg_k), .cfg_w(cfg_w),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_mult_seln(pe_mult_seln),
    .pe_acc_seln(pe_acc_seln), .pe_psum(pe_psum),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PE: accumulator plus three delay stages, final sum PE_LAT cycles after last tap
  logic signed [2*DW-1:0] pe_acc, pe_d0, pe_d1, pe_d2;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pe_acc <= '0; pe_d0 <= '0; pe_d1 <= '0; pe_d2 <= '0;
    end else begin
      if (pe_mult_seln)
        pe_acc <= (pe_acc_seln ? 32'sd0 : pe_acc) + $signed(pe_ifmap) * $signed(pe_fltr);
      pe_d0 <= pe_acc;
      pe_d1 <= pe_d0;
      pe_d2 <= pe_d1;
    end
  end
  assign pe_psum = pe_d2;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  logic signed [DW-1:0] f_arr [MAX_K];
  logic signed [DW-1:0] x_arr [MAX_W];
  logic [DW-1:0]   fq[$], iq[$];
  logic [2*DW-1:0] eq[$], got_q[$];
  int t_rise[$], t_acc[$];
  int fvp = 100, ivp = 100, rprob = 100, hold_idx = -1, hold_left = 0;
  bit env_en = 0, inj = 0, inj_on = 0;
  int n_acc = 0, n_ifm = 0, n_done = 0, t_done = 0, t_start = 0;
  bit pv_prev = 0, acc_prev = 0, acc_now = 0;
  logic [2*DW-1:0] pd_prev = '0;

  // Stream environment: decides valids/readies on the falling edge against the registered
  // readies/valids of the DUT, so a transfer is known before the rising edge commits it.
  initial forever begin
    @(negedge clk);
    if (env_en) begin
      if (pv_prev && !acc_prev) chk("psum_held", {psum_valid, psum_data}, {1'b1, pd_prev});
      if (psum_valid && !pv_prev) t_rise.push_back(cyc);
      if (n_acc == hold_idx && hold_left > 0) begin
        psum_ready = 1'b0;
        if (psum_valid) hold_left--;
      end else begin
        psum_ready = ($urandom_range(0, 99) < rprob);
      end
      acc_now = psum_valid && psum_ready;
      if (acc_now) begin
        if (eq.size() == 0) chk("psum_unexpected", 1, 0);
        else chk($sformatf("psum[%0d]", n_acc), psum_data, eq.pop_front());
        got_q.push_back(psum_data);
        t_acc.push_back(cyc);
        n_acc++;
      end
      pv_prev = psum_valid; pd_prev = psum_data; acc_prev = acc_now;

      fltr_valid = (fq.size() > 0) && ($urandom_range(0, 99) < fvp);
      fltr_data  = fltr_valid ? fq[0] : DW'($urandom);
      if (fltr_valid && fltr_ready) void'(fq.pop_front());
      ifmap_valid = (iq.size() > 0) && ($urandom_range(0, 99) < ivp);
      ifmap_data  = ifmap_valid ? iq[0] : DW'($urandom);
      if (ifmap_valid && ifmap_ready) begin
        void'(iq.pop_front());
        n_ifm++;
      end

      if (done) begin
        n_done++;
        t_done = cyc;
        chk("busy_low_at_done", busy, 1'b0);
      end
      if (inj_on) begin
        start = 1'b0; inj_on = 1'b0; inj = 1'b0;
      end else if (inj && pe_mult_seln) begin
        start = 1'b1; cfg_k = KW'(2); cfg_w = WW'(9); inj_on = 1'b1;
      end
    end else begin
      fltr_valid = 1'b0; ifmap_valid = 1'b0; psum_ready = 1'b0;
      pv_prev = 1'b0; acc_prev = 1'b0;
    end
  end

  task automatic load_row(input int k, input int w, input bit rnd);
    int s;
    if (rnd) begin
      for (int i = 0; i < MAX_K; i++) f_arr[i] = DW'($urandom);
      for (int i = 0; i < MAX_W; i++) x_arr[i] = DW'($urandom);
    end
    fq.delete(); iq.delete(); eq.delete(); got_q.delete(); t_rise.delete(); t_acc.delete();
    n_acc = 0; n_ifm = 0;
    for (int i = 0; i < k; i++) fq.push_back(f_arr[i]);
    for (int i = 0; i < w; i++) iq.push_back(x_arr[i]);
    for (int o = 0; o <= w - k; o++) begin
      s = 0;
      for (int i = 0; i < k; i++) s += int'(f_arr[i]) * int'(x_arr[o + i]);
      eq.push_back(s);
    end
    @(negedge clk); #1;
    start = 1'b1; cfg_k = KW'(k); cfg_w = WW'(w); t_start = cyc;
    @(negedge clk); #1;
    start = 1'b0; cfg_k = KW'($urandom); cfg_w = WW'($urandom);
  endtask

  task automatic do_reset();
    env_en = 1'b0; start = 1'b0;
    @(negedge clk); #2; rstn = 1'b0;
    @(negedge clk); #1; rstn = 1'b1;
    fq.delete(); iq.delete(); eq.delete();
    inj = 1'b0; inj_on = 1'b0; hold_idx = -1;
    env_en = 1'b1;
  endtask

  task automatic finish_row(input int k, input int w, input bit tmg);
    int  base;
    bit  ok;
    base = n_done - ((done === 1'b1) ? 1 : 0);
    for (int i = 0; i < 3000 && n_done == base; i++) begin @(negedge clk); #1; end
    ok = (n_done == base + 1);
    chk("row_done", n_done - base, 1);
    chk("row_outputs", n_acc, w - k + 1);
    chk("row_exp_left", eq.size(), 0);
    chk("row_fltr_left", fq.size(), 0);
    chk("row_ifmap_taken", n_ifm, w);
    if (ok && t_acc.size() > 0) chk("done_after_accept", t_done - t_acc[t_acc.size()-1], 1);
    if (tmg) begin
      if (t_rise.size() == w - k + 1) begin
        chk("first_latency", t_rise[0] - t_start, 3 * k + PE_LAT + 1);
        for (int o = 1; o < t_rise.size(); o++)
          chk("spacing", t_rise[o] - t_acc[o-1], k + PE_LAT + 2);
      end else begin
        chk("rise_count", t_rise.size(), w - k + 1);
      end
    end
    if (!ok) do_reset();
  endtask

  task automatic run_row(input int k, input int w, input bit rnd, input bit tmg);
    load_row(k, w, rnd);
    finish_row(k, w, tmg);
  endtask

  task automatic set_basic();
    for (int i = 0; i < 3; i++) f_arr[i] = DW'(i + 1);
    for (int i = 0; i < 5; i++) x_arr[i] = DW'(i + 1);
  endtask

  task automatic chk_basic(input string tag);
    logic [2*DW-1:0] g;
    int exp_b [3];
    exp_b = '{14, 20, 26};
    for (int i = 0; i < 3; i++) begin
      g = (i < got_q.size()) ? got_q[i] : '1;
      chk($sformatf("%s_out%0d", tag, i), g, exp_b[i]);
    end
  endtask

  typedef struct {
    int k; int w; bit exp_err; bit exp_busy;
  } cfg_vec_t;
  cfg_vec_t cfg_tab [8];

  initial begin
    int base;
    int k, w;
    bit full;
    cfg_tab[0] = '{0, 5, 1'b1, 1'b0};
    cfg_tab[1] = '{3, 2, 1'b1, 1'b0};
    cfg_tab[2] = '{3, 65, 1'b1, 1'b0};
    cfg_tab[3] = '{7, 6, 1'b1, 1'b0};
    cfg_tab[4] = '{0, 0, 1'b1, 1'b0};
    cfg_tab[5] = '{1, 1, 1'b0, 1'b1};
    cfg_tab[6] = '{7, 64, 1'b0, 1'b1};
    cfg_tab[7] = '{3, 3, 1'b0, 1'b1};

    // reset state
    #12;
    chk("rst_ctrl", {busy, done, cfg_err, fltr_ready, ifmap_ready, pe_mult_seln,
                     pe_acc_seln, psum_valid}, 8'b0000_0010);
    chk("rst_ops", {pe_ifmap, pe_fltr}, '0);
    chk("rst_psum", psum_data, '0);
    @(negedge clk); rstn = 1'b1; env_en = 1'b1;
    @(negedge clk); #1;
    chk("idle_ctrl", {busy, fltr_ready, ifmap_ready, pe_acc_seln, psum_valid}, 5'b00010);

    // configuration table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      start = 1'b1; cfg_k = KW'(cfg_tab[i].k); cfg_w = WW'(cfg_tab[i].w);
      @(negedge clk); #1;
      start = 1'b0;
      chk($sformatf("cfg%0d_resp", i), {cfg_err, busy, fltr_ready},
          {cfg_tab[i].exp_err, cfg_tab[i].exp_busy, cfg_tab[i].exp_busy});
      @(negedge clk); #1;
      chk($sformatf("cfg%0d_pulse", i), {cfg_err, busy}, {1'b0, cfg_tab[i].exp_busy});
      do_reset();
    end

    // basic row, no stalls
    set_basic();
    run_row(3, 5, 1'b0, 1'b1);
    chk_basic("basic");

    // backpressure on output 2 and gapped ifmap in SHIFT
    hold_idx = 1; hold_left = 5; ivp = 50;
    run_row(3, 5, 1'b0, 1'b0);
    chk_basic("bp");
    chk("bp_hold_used", hold_left, 0);
    hold_idx = -1; ivp = 100;

    // minimum case K=W=1
    f_arr[0] = -16'sd2; x_arr[0] = 16'sd7;
    run_row(1, 1, 1'b0, 1'b1);
    chk("min_psum", (got_q.size() > 0) ? got_q[0] : '0, 32'hFFFF_FFF2);

    // start during MAC is ignored
    set_basic();
    inj = 1'b1;
    run_row(3, 5, 1'b0, 1'b1);
    chk_basic("busy_start");

    // reset during the drain of output 2
    load_row(3, 5, 1'b0);
    for (int i = 0; i < 200 && n_acc < 1; i++) begin @(negedge clk); #1; end
    chk("mr_first_out", n_acc, 1);
    repeat (6) @(negedge clk);
    #1;
    chk("mr_in_drain", {busy, pe_mult_seln, pe_acc_seln, psum_valid}, 4'b1000);
    base = n_done; env_en = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("mr_rst_ctrl", {busy, done, cfg_err, fltr_ready, ifmap_ready, pe_mult_seln,
                        pe_acc_seln, psum_valid}, 8'b0000_0010);
    chk("mr_rst_psum", psum_data, '0);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    fq.delete(); iq.delete(); eq.delete();
    env_en = 1'b1;
    repeat (6) begin @(negedge clk); #1; end
    chk("mr_no_done", n_done - base, 0);
    chk("mr_idle", busy, 1'b0);
    run_row(3, 5, 1'b1, 1'b1);

    // randomized rows
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(1, MAX_K);
      w = (r == 0) ? MAX_W : $urandom_range(k, k + 10);
      full = (r % 3 == 1);
      fvp   = full ? 100 : $urandom_range(40, 100);
      ivp   = full ? 100 : $urandom_range(40, 100);
      rprob = full ? 100 : $urandom_range(40, 100);
      run_row(k, w, 1'b1, full);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
